// File: rtl/cache_control_nway_if.sv
// rtl/cache_control_nway_if.sv - CPU, memory and array-control signal bundle for the n-way cache controller
interface cache_control_nway_if #(
  parameter int WAY_W = 1,
  parameter int CNT_W = 32
);
  logic             mem_read;
  logic             mem_write;
  logic             cache_hit;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] plru_way;
  logic             victim_dirty;
  logic             stall;
  logic             resp_from_mem;

  logic             read_from_mem;
  logic             write_to_mem;
  logic [WAY_W-1:0] way_sel;
  logic             tag_sel;
  logic             source_sel;
  logic             addrmux_sel;
  logic             load_cache;
  logic             load_lru;
  logic             load_dirty;
  logic             dirty_in;
  logic             stall_regs;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] miss_count;
  logic [CNT_W-1:0] wb_count;

  modport master (
    output mem_read, mem_write, cache_hit, hit_way, plru_way, victim_dirty, stall, resp_from_mem,
    input  read_from_mem, write_to_mem, way_sel, tag_sel, source_sel, addrmux_sel,
           load_cache, load_lru, load_dirty, dirty_in, stall_regs,
           hit_count, miss_count, wb_count
  );

  modport slave (
    input  mem_read, mem_write, cache_hit, hit_way, plru_way, victim_dirty, stall, resp_from_mem,
    output read_from_mem, write_to_mem, way_sel, tag_sel, source_sel, addrmux_sel,
           load_cache, load_lru, load_dirty, dirty_in, stall_regs,
           hit_count, miss_count, wb_count
  );
endinterface

// File: rtl/cache_control_nway.sv
// rtl/cache_control_nway.sv - miss-handling FSM, victim selection and saturating perf counters for an n-way cache
module cache_control_nway #(
  parameter int WAYS      = 2,
  parameter int WAY_W     = $clog2(WAYS),
  parameter int REPL_MODE = 0,
  parameter int CNT_W     = 32
) (
  input logic                 clk,
  input logic                 rst,
  cache_control_nway_if.slave bus
);

  typedef enum logic [2:0] {IDLE, WRITE_BACK, FETCH, FILL, RESPOND} state_t;

  state_t           state_q, state_d;
  logic [WAY_W-1:0] victim_q, victim_d;
  logic [WAY_W-1:0] rr_q, rr_d;
  logic [CNT_W-1:0] hit_q, hit_d;
  logic [CNT_W-1:0] miss_q, miss_d;
  logic [CNT_W-1:0] wb_q, wb_d;

  logic             req;
  logic             hit_dec, miss_dec, wb_done, fill_cyc;
  logic             rd_mem, wr_mem, tag_s, src_s, addr_s;
  logic             ld_cache, ld_lru, ld_dirty, d_in, st_regs;
  logic [WAY_W-1:0] way_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
    return (en && (c != '1)) ? c + 1'b1 : c;
  endfunction

  assign req = bus.mem_read | bus.mem_write;

  always_comb begin
    state_d  = state_q;
    hit_dec  = 1'b0;
    miss_dec = 1'b0;
    wb_done  = 1'b0;
    fill_cyc = 1'b0;
    way_s    = bus.hit_way;
    tag_s    = 1'b1;
    rd_mem   = 1'b0;
    wr_mem   = 1'b0;
    src_s    = 1'b0;
    addr_s   = 1'b0;
    ld_cache = 1'b0;
    ld_lru   = 1'b0;
    ld_dirty = 1'b0;
    d_in     = 1'b0;
    st_regs  = 1'b0;
    case (state_q)
      IDLE, RESPOND: begin
        if (state_q == RESPOND) begin
          ld_lru   = 1'b1;
          ld_cache = bus.mem_write;
          ld_dirty = bus.mem_write;
          d_in     = bus.mem_write;
        end
        // RESPOND doubles as a decision point so back-to-back requests need no IDLE bubble
        if (req) begin
          if (bus.cache_hit) begin
            hit_dec = 1'b1;
            state_d = RESPOND;
          end else begin
            miss_dec = 1'b1;
            state_d  = bus.victim_dirty ? WRITE_BACK : FETCH;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WRITE_BACK: begin
        wr_mem  = 1'b1;
        tag_s   = 1'b0;
        way_s   = victim_q;
        addr_s  = 1'b1;
        st_regs = 1'b1;
        if (bus.resp_from_mem) begin
          wb_done = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        rd_mem  = 1'b1;
        way_s   = victim_q;
        addr_s  = 1'b1;
        st_regs = 1'b1;
        if (bus.resp_from_mem) state_d = FILL;
      end
      FILL: begin
        fill_cyc = 1'b1;
        ld_cache = 1'b1;
        src_s    = 1'b1;
        ld_dirty = 1'b1;
        way_s    = victim_q;
        addr_s   = 1'b1;
        st_regs  = 1'b1;
        state_d  = RESPOND;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    victim_d = victim_q;
    rr_d     = rr_q;
    if (miss_dec) victim_d = (REPL_MODE == 1) ? rr_q : bus.plru_way;
    // The round-robin pointer advances only once the victim line has actually been refilled
    if (fill_cyc) rr_d = (rr_q == WAY_W'(WAYS - 1)) ? '0 : rr_q + 1'b1;
    hit_d  = sat_inc(hit_q, hit_dec);
    miss_d = sat_inc(miss_q, miss_dec);
    wb_d   = sat_inc(wb_q, wb_done);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      victim_q <= '0;
      rr_q     <= '0;
      hit_q    <= '0;
      miss_q   <= '0;
      wb_q     <= '0;
    end else if (!bus.stall) begin
      state_q  <= state_d;
      victim_q <= victim_d;
      rr_q     <= rr_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
      wb_q     <= wb_d;
    end
  end

  assign bus.read_from_mem = rd_mem;
  assign bus.write_to_mem  = wr_mem;
  assign bus.way_sel       = way_s;
  assign bus.tag_sel       = tag_s;
  assign bus.source_sel    = src_s;
  assign bus.addrmux_sel   = addr_s;
  assign bus.load_cache    = ld_cache;
  assign bus.load_lru      = ld_lru;
  assign bus.load_dirty    = ld_dirty;
  assign bus.dirty_in      = d_in;
  assign bus.stall_regs    = st_regs;
  assign bus.hit_count     = hit_q;
  assign bus.miss_count    = miss_q;
  assign bus.wb_count      = wb_q;

endmodule
